// File: rtl/snn_sched_pkg.sv
// Shared definitions for the SNN timestep scheduler.
//   - 3-bit FSM state encoding, as plain localparams and as the typed enum the FSM uses
//   - Default frame widths and the default RUN-phase timeout
package snn_sched_pkg;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WAIT_FRAME = 3'd1;
  localparam logic [2:0] LOAD       = 3'd2;
  localparam logic [2:0] RUN        = 3'd3;
  localparam logic [2:0] EMIT       = 3'd4;

  typedef enum logic [2:0] {
    StIdle      = IDLE,
    StWaitFrame = WAIT_FRAME,
    StLoad      = LOAD,
    StRun       = RUN,
    StEmit      = EMIT
  } sched_state_e;

  localparam int unsigned NInDefault     = 8;
  localparam int unsigned NOutDefault    = 8;
  localparam int unsigned TimeoutDefault = 255;

endpackage

// File: rtl/snn_frame_fifo.sv
// Synchronous FIFO that buffers input spike frames ahead of the SNN.
// Parameters: DEPTH (power of two, >= 2) entries of WIDTH bits.
// Ports:
//   clk_i   clock
//   rst_i   synchronous active-high reset; empties the FIFO
//   push_i  write data_i (ignored when full)
//   pop_i   drop the head entry (ignored when empty)
//   data_i  write payload
//   head_o  entry at the read pointer
//   full_o  DEPTH entries held
//   empty_o no entries held
module snn_frame_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A push on a full FIFO is refused even if a pop happens in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/snn_timestep_scheduler.sv
// Runs the SNN core for a programmed number of timesteps. Input frames are buffered in a
// small FIFO; each step loads one frame, enables the SNN, waits for its output-ready strobe
// (bounded by TIMEOUT_CYCLES) and publishes the captured spikes with a 0-based step index.
// Optional build macro: SNN_SPIKE_COUNT_EN adds saturating per-neuron spike counters
// (parameter CNT_W, output spike_count).
// Ports:
//   system_clock, sys_clk_reset   clock, synchronous active-high reset
//   start, num_steps              run request pulse and step count (latched on accept)
//   frame_valid/frame_data/frame_ready   frame push interface into the FIFO
//   snn_input_spikes/snn_input_ready     frame and load strobe towards the SNN
//   snn_enable                    high only while waiting for the SNN result
//   snn_output_ready/snn_output_spikes  SNN result strobe and layer-2 spikes
//   result_valid/result_spikes/result_step  one-cycle published result
//   busy, done, timeout_err       run status; timeout_err sticky until next accepted start
//   spike_count                   per-neuron totals (SNN_SPIKE_COUNT_EN only)
module snn_timestep_scheduler
  import snn_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned N_IN           = NInDefault,
  parameter int unsigned N_OUT          = NOutDefault,
`ifdef SNN_SPIKE_COUNT_EN
  parameter int unsigned CNT_W          = 8,
`endif
  parameter int unsigned TIMEOUT_CYCLES = TimeoutDefault
) (
  input  logic                   system_clock,
  input  logic                   sys_clk_reset,
  input  logic                   start,
  input  logic [7:0]             num_steps,
  input  logic                   frame_valid,
  input  logic [N_IN-1:0]        frame_data,
  output logic                   frame_ready,
  output logic [N_IN-1:0]        snn_input_spikes,
  output logic                   snn_input_ready,
  output logic                   snn_enable,
  input  logic                   snn_output_ready,
  input  logic [N_OUT-1:0]       snn_output_spikes,
  output logic                   result_valid,
  output logic [N_OUT-1:0]       result_spikes,
  output logic [7:0]             result_step,
  output logic                   busy,
  output logic                   done,
`ifdef SNN_SPIKE_COUNT_EN
  output logic [N_OUT*CNT_W-1:0] spike_count,
`endif
  output logic                   timeout_err
);

  localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);

  sched_state_e     state_q;
  logic [7:0]       num_steps_q;
  logic [7:0]       step_q;
  logic [7:0]       tmo_q;
  logic             ready_en_q;
  logic [N_IN-1:0]  in_spikes_q;
  logic             in_ready_q;
  logic             enable_q;
  logic             res_valid_q;
  logic [N_OUT-1:0] res_spikes_q;
  logic [7:0]       res_step_q;
  logic             busy_q;
  logic             done_q;
  logic             tmo_err_q;

  logic             start_accept;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [N_IN-1:0]  fifo_head;

  // ready_en_q keeps frame_ready low during reset and for the first cycle after it.
  assign frame_ready  = ready_en_q && !fifo_full;
  assign fifo_push    = frame_valid && frame_ready;
  assign fifo_pop     = (state_q == StLoad);
  assign start_accept = (state_q == StIdle) && start && (num_steps != '0);

  snn_frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (N_IN)
  ) u_fifo (
    .clk_i   (system_clock),
    .rst_i   (sys_clk_reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (frame_data),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Outputs are registered on the transition into the state in which they are visible:
  // snn_input_ready during LOAD, snn_enable during RUN, result_valid during EMIT, and
  // done in the cycle after the run ends.
  always_ff @(posedge system_clock) begin
    if (sys_clk_reset) begin
      state_q      <= StIdle;
      num_steps_q  <= '0;
      step_q       <= '0;
      tmo_q        <= '0;
      ready_en_q   <= 1'b0;
      in_spikes_q  <= '0;
      in_ready_q   <= 1'b0;
      enable_q     <= 1'b0;
      res_valid_q  <= 1'b0;
      res_spikes_q <= '0;
      res_step_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tmo_err_q    <= 1'b0;
    end else begin
      ready_en_q  <= 1'b1;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_accept) begin
            num_steps_q <= num_steps;
            step_q      <= '0;
            tmo_err_q   <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= StWaitFrame;
          end else if (start) begin
            // Zero-step run: report completion without ever going busy.
            done_q <= 1'b1;
          end
        end
        StWaitFrame: begin
          if (!fifo_empty) begin
            in_spikes_q <= fifo_head;
            in_ready_q  <= 1'b1;
            state_q     <= StLoad;
          end
        end
        StLoad: begin
          enable_q <= 1'b1;
          tmo_q    <= '0;
          state_q  <= StRun;
        end
        StRun: begin
          if (snn_output_ready) begin
            enable_q     <= 1'b0;
            res_spikes_q <= snn_output_spikes;
            res_step_q   <= step_q;
            res_valid_q  <= 1'b1;
            state_q      <= StEmit;
          end else if (tmo_q == TmoLast) begin
            enable_q  <= 1'b0;
            tmo_err_q <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= StIdle;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        StEmit: begin
          step_q <= step_q + 8'd1;
          if (step_q + 8'd1 == num_steps_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            state_q <= StWaitFrame;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign snn_input_spikes = in_spikes_q;
  assign snn_input_ready  = in_ready_q;
  assign snn_enable       = enable_q;
  assign result_valid     = res_valid_q;
  assign result_spikes    = res_spikes_q;
  assign result_step      = res_step_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign timeout_err      = tmo_err_q;

`ifdef SNN_SPIKE_COUNT_EN
  logic [N_OUT-1:0][CNT_W-1:0] cnt_q;

  // res_spikes_q holds the captured spikes throughout EMIT.
  always_ff @(posedge system_clock) begin
    if (sys_clk_reset || start_accept) begin
      cnt_q <= '0;
    end else if (state_q == StEmit) begin
      for (int unsigned i = 0; i < N_OUT; i++) begin
        if (res_spikes_q[i] && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign spike_count = cnt_q;
`endif

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Self-checking bench for snn_timestep_scheduler: directed table run, multi-cycle corner
// sequences, then randomized runs against a frame-queue reference model.
module tb_snn_timestep_scheduler;

  localparam int DEPTH = 4;
  localparam int TMO   = 20;
  localparam int CNTW  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] num_steps;
  logic       frame_valid;
  logic [7:0] frame_data;
  logic       frame_ready;
  logic [7:0] snn_input_spikes;
  logic       snn_input_ready;
  logic       snn_enable;
  logic       snn_output_ready;
  logic [7:0] snn_output_spikes;
  logic       result_valid;
  logic [7:0] result_spikes;
  logic [7:0] result_step;
  logic       busy;
  logic       done;
  logic       timeout_err;
`ifdef SNN_SPIKE_COUNT_EN
  logic [8*CNTW-1:0] spike_count;
`endif

  always #5 clk = ~clk;

  snn_timestep_scheduler #(
    .FIFO_DEPTH     (DEPTH),
    .N_IN           (8),
    .N_OUT          (8),
`ifdef SNN_SPIKE_COUNT_EN
    .CNT_W          (CNTW),
`endif
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .system_clock      (clk),
    .sys_clk_reset     (rst),
    .start             (start),
    .num_steps         (num_steps),
    .frame_valid       (frame_valid),
    .frame_data        (frame_data),
    .frame_ready       (frame_ready),
    .snn_input_spikes  (snn_input_spikes),
    .snn_input_ready   (snn_input_ready),
    .snn_enable        (snn_enable),
    .snn_output_ready  (snn_output_ready),
    .snn_output_spikes (snn_output_spikes),
    .result_valid      (result_valid),
    .result_spikes     (result_spikes),
    .result_step       (result_step),
    .busy              (busy),
    .done              (done),
`ifdef SNN_SPIKE_COUNT_EN
    .spike_count       (spike_count),
`endif
    .timeout_err       (timeout_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- SNN responder model ----------------
  int         lat = 5;
  logic [7:0] key = 8'hFF;
  bit         resp_en = 1'b1;
  bit         resp_force = 1'b0;
  logic [7:0] resp_val = 8'h00;
  int         rcnt = 0;
  logic [7:0] rdata;

  initial begin
    snn_output_ready  = 1'b0;
    snn_output_spikes = 8'h00;
  end

  always @(negedge clk) begin
    snn_output_ready = 1'b0;
    if (rcnt > 0) begin
      rcnt--;
      if (rcnt == 0) begin
        snn_output_ready  = 1'b1;
        snn_output_spikes = rdata;
      end
    end
    if (snn_input_ready && resp_en) begin
      rcnt  = lat;
      rdata = resp_force ? resp_val : (snn_input_spikes ^ key);
    end
  end

  // ---------------- Monitor ----------------
  typedef struct {
    logic [7:0] spikes;
    logic [7:0] step;
    int         cyc;
  } res_t;

  res_t res_q[$];
  int   cyc = 0;
  int   done_cnt = 0, done_cyc = 0, load_cnt = 0, load_cyc = 0, en_cycles = 0, busy_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (result_valid) res_q.push_back('{result_spikes, result_step, cyc});
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (snn_input_ready) begin
      load_cnt++;
      load_cyc = cyc;
    end
    if (snn_enable) en_cycles++;
    if (busy) busy_cycles++;
  end

  // ---------------- Reference model: frames held in the FIFO ----------------
  logic [7:0] mq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, output bit ok);
    frame_valid = 1'b1;
    frame_data  = d;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      ok = frame_ready;
      tick();
    end
    frame_valid = 1'b0;
    if (ok) mq.push_back(d);
  endtask

  task automatic do_start(input logic [7:0] steps);
    num_steps = steps;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    check("busy_after_start", busy, (steps != 0));
  endtask

  task automatic wait_done(input int d0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0] frame;
    logic [7:0] exp_spikes;
    logic [7:0] exp_step;
  } vec_t;

  vec_t vecs[3];

  initial begin
    bit ok;
    int d0, r0, l0, e0, b0, first_k, steps, npush;
    logic [7:0] exp_s;

    vecs[0] = '{8'h01, 8'hFE, 8'd0};
    vecs[1] = '{8'h02, 8'hFD, 8'd1};
    vecs[2] = '{8'h03, 8'hFC, 8'd2};

    rst = 1'b1; start = 1'b0; num_steps = 8'd0; frame_valid = 1'b0; frame_data = 8'd0;
    repeat (3) tick();
    check("rst_frame_ready", frame_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_enable", snn_enable, 0);
    check("rst_outputs", {snn_input_ready, result_valid, done, timeout_err}, 0);
    rst = 1'b0;
    tick();
    check("ready_after_reset", frame_ready, 1);

    // ---- Directed table run: 3 steps, SNN answers 5 cycles after each load ----
    lat = 5; key = 8'hFF; resp_en = 1'b1;
    foreach (vecs[i]) begin
      push(vecs[i].frame, ok);
      check("t1_push", ok, 1);
    end
    r0 = res_q.size(); d0 = done_cnt;
    do_start(8'd3);
    wait_done(d0, 300, ok);
    check("t1_done", ok, 1);
    check("t1_count", res_q.size() - r0, 3);
    if (res_q.size() - r0 == 3) begin
      foreach (vecs[i]) begin
        check("t1_spikes", res_q[r0+i].spikes, vecs[i].exp_spikes);
        check("t1_step", res_q[r0+i].step, vecs[i].exp_step);
      end
      check("t1_done_lag", done_cyc - res_q[$].cyc, 1);
      check("t1_latency", res_q[$].cyc - load_cyc, 6);
    end
    check("t1_busy_end", busy, 0);
    repeat (3) void'(mq.pop_front());

    // ---- FIFO full: 5th frame held until the LOAD pop ----
    for (int i = 0; i < 4; i++) begin
      push(8'h10 + 8'(i), ok);
      check("t2_push", ok, 1);
    end
    frame_valid = 1'b1; frame_data = 8'h14;
    check("t2_full", frame_ready, 0);
    tick(); tick();
    check("t2_held", frame_ready, 0);
    d0 = done_cnt; r0 = res_q.size();
    num_steps = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    first_k = -1;
    for (int k = 0; k < 10; k++) begin
      if (frame_ready) begin
        first_k = k;
        tick();
        break;
      end
      tick();
    end
    frame_valid = 1'b0;
    check("t2_ready_after_pop", first_k, 2);
    void'(mq.pop_front());
    mq.push_back(8'h14);
    wait_done(d0, 100, ok);
    check("t2_done", ok, 1);
    check("t2_result", (res_q.size() > r0) ? res_q[r0].spikes : 8'hxx, 8'h10 ^ key);
    check("t2_ready_model", frame_ready, (mq.size() < DEPTH));

    // ---- num_steps = 0 ----
    d0 = done_cnt; l0 = load_cnt; b0 = busy_cycles;
    do_start(8'd0);
    check("t3_done_pulse", done, 1);
    tick();
    check("t3_done_one_cycle", done, 0);
    repeat (3) tick();
    check("t3_done_count", done_cnt - d0, 1);
    check("t3_no_load", load_cnt - l0, 0);
    check("t3_never_busy", busy_cycles - b0, 0);

    // ---- Timeout ----
    resp_en = 1'b0;
    d0 = done_cnt; r0 = res_q.size(); e0 = en_cycles;
    do_start(8'd2);
    wait_done(d0, TMO + 60, ok);
    check("t4_done", ok, 1);
    check("t4_enable_cycles", en_cycles - e0, TMO);
    check("t4_no_result", res_q.size() - r0, 0);
    check("t4_busy", busy, 0);
    repeat (3) tick();
    check("t4_err_sticky", timeout_err, 1);
    check("t4_single_done", done_cnt - d0, 1);
    void'(mq.pop_front());
    resp_en = 1'b1;
    d0 = done_cnt; r0 = res_q.size();
    do_start(8'd1);
    check("t4_err_cleared", timeout_err, 0);
    wait_done(d0, 100, ok);
    exp_s = mq.pop_front() ^ key;
    check("t4_next_result", (res_q.size() > r0) ? res_q[r0].spikes : 8'hxx, exp_s);

    // ---- Reset mid-run ----
    resp_en = 1'b0;
    d0 = done_cnt; r0 = res_q.size();
    do_start(8'd1);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = snn_enable;
      tick();
    end
    check("t5_reached_run", ok, 1);
    tick();
    rst = 1'b1;
    tick();
    check("t5_rst_enable_busy", {snn_enable, busy, frame_ready}, 0);
    check("t5_rst_data", {snn_input_spikes, result_spikes, result_step}, 0);
    check("t5_rst_strobes", {snn_input_ready, result_valid, done, timeout_err}, 0);
    rst = 1'b0;
    mq.delete();
    tick();
    check("t5_ready_back", frame_ready, 1);
    repeat (4) tick();
    check("t5_no_done", done_cnt - d0, 0);
    check("t5_no_result", res_q.size() - r0, 0);
    resp_en = 1'b1;
    l0 = load_cnt; d0 = done_cnt; r0 = res_q.size();
    do_start(8'd1);
    repeat (10) tick();
    check("t5_fifo_empty", load_cnt - l0, 0);
    push(8'h5A, ok);
    wait_done(d0, 100, ok);
    check("t5_done", ok, 1);
    exp_s = mq.pop_front() ^ key;
    check("t5_result", (res_q.size() > r0) ? res_q[r0].spikes : 8'hxx, exp_s);

`ifdef SNN_SPIKE_COUNT_EN
    // ---- Saturating spike counters ----
    begin
      logic [8*CNTW-1:0] exp_cnt;
      resp_force = 1'b1; resp_val = 8'h81;
      for (int i = 0; i < 4; i++) push(8'($urandom), ok);
      d0 = done_cnt; r0 = res_q.size();
      do_start(8'd5);
      push(8'($urandom), ok);
      wait_done(d0, 300, ok);
      check("t6_done", ok, 1);
      check("t6_count", res_q.size() - r0, 5);
      exp_cnt = '0;
      for (int i = 0; i < 8; i++) begin
        int n;
        n = resp_val[i] ? 5 : 0;
        if (n > (1 << CNTW) - 1) n = (1 << CNTW) - 1;
        exp_cnt[i*CNTW +: CNTW] = CNTW'(n);
      end
      tick();
      check("t6_spike_count", spike_count, exp_cnt);
      mq.delete();
      resp_force = 1'b0;
    end
`endif

    // ---- Randomized runs against the frame-queue model ----
    for (int it = 0; it < 25; it++) begin
      npush = $urandom_range(DEPTH - mq.size(), (mq.size() == 0) ? 1 : 0);
      for (int i = 0; i < npush; i++) begin
        push(8'($urandom), ok);
        check("rnd_push", ok, 1);
      end
      check("rnd_ready", frame_ready, (mq.size() < DEPTH));
      steps = $urandom_range(mq.size(), 1);
      lat   = $urandom_range(8, 1);
      key   = 8'($urandom);
      d0 = done_cnt; r0 = res_q.size(); l0 = load_cnt; e0 = en_cycles;
      do_start(8'(steps));
      wait_done(d0, steps * (lat + 10) + 20, ok);
      check("rnd_done", ok, 1);
      check("rnd_count", res_q.size() - r0, steps);
      check("rnd_loads", load_cnt - l0, steps);
      check("rnd_enable_cycles", en_cycles - e0, steps * lat);
      for (int s = 0; s < steps; s++) begin
        exp_s = mq.pop_front() ^ key;
        if (r0 + s < res_q.size()) begin
          check("rnd_spikes", res_q[r0+s].spikes, exp_s);
          check("rnd_step", res_q[r0+s].step, s);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snn_timestep_scheduler.md
Name: snn_timestep_scheduler

Overview:
Sequences the spiking network across a programmed number of timesteps. Buffers incoming 8-bit input spike frames in a small FIFO. For each step it loads one frame into the SNN, enables it, and waits for its output-ready strobe. It then publishes the layer-2 output spikes with a step index. Sits in the system_clock domain between the host/pad-side frame source and the SNN core, replacing raw input_ready/SNN_en pin control.

Parameters:
FIFO_DEPTH, 4, input frame buffer entries (power of two, >=2)
N_IN, 8, input spike frame width
N_OUT, 8, output spike width
TIMEOUT_CYCLES, 255, max RUN cycles waiting for snn_output_ready (1..255)
CNT_W, 8, per-neuron spike counter width (only with SNN_SPIKE_COUNT_EN)

Ports:
system_clock  in  1  clock
sys_clk_reset  in  1  reset, synchronous, active-high
start  in  1  single-cycle pulse; begins a run (ignored while busy)
num_steps  in  8  timesteps per run; latched on accepted start
frame_valid  in  1  frame push request
frame_data  in  N_IN  frame payload
frame_ready  out  1  FIFO not full
snn_input_spikes  out  N_IN  frame presented to SNN input register
snn_input_ready  out  1  one-cycle load strobe
snn_enable  out  1  SNN enable
snn_output_ready  in  1  SNN result strobe
snn_output_spikes  in  N_OUT  SNN layer-2 spikes
result_valid  out  1  one-cycle result strobe
result_spikes  out  N_OUT  captured output spikes
result_step  out  8  step index of result (0-based)
busy  out  1  run in progress
done  out  1  one-cycle end-of-run pulse
timeout_err  out  1  sticky until next accepted start
spike_count  out  N_OUT*CNT_W  per-neuron totals (SNN_SPIKE_COUNT_EN only)

Behaviour:
- Reset: all outputs 0; FIFO emptied; FSM=IDLE; step counter 0; timeout_err 0. frame_ready becomes 1 the cycle after reset deasserts.
- FIFO:
  - Push on frame_valid&&frame_ready. frame_ready = !full, registered-state based, no bypass.
  - Simultaneous push+pop when full: the pop occurs and the push is refused.
  - Push+pop when non-full and non-empty: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - FIFO contents persist across runs; start does not flush.
- FSM states: IDLE, WAIT_FRAME, LOAD, RUN, EMIT.
  - IDLE:
    - start && num_steps!=0 -> latch num_steps, clear step counter and timeout_err, busy=1, go WAIT_FRAME.
    - start && num_steps==0 -> done pulse next cycle, stay IDLE, busy stays 0.
  - WAIT_FRAME: FIFO non-empty -> LOAD.
  - LOAD (1 cycle): snn_input_spikes<=head, snn_input_ready=1, pop, -> RUN. snn_input_spikes holds its value until the next LOAD.
  - RUN: snn_enable=1 and timeout counter increments.
    - snn_output_ready=1 -> capture snn_output_spikes, -> EMIT.
    - Counter reaches TIMEOUT_CYCLES without the strobe -> timeout_err=1, snn_enable=0, done pulse, busy=0, -> IDLE. No result is emitted.
  - EMIT (1 cycle): result_valid=1 with result_spikes/result_step, step++.
    - step+1==num_steps -> done=1, busy=0, -> IDLE.
    - else -> WAIT_FRAME.
- Latency: LOAD to RUN is 1 cycle; snn_output_ready to result_valid is 1 cycle. Best-case step period is 3 cycles plus SNN latency.
- snn_enable=1 only in RUN. snn_output_ready outside RUN is ignored.
- The step counter is 8-bit; num_steps=255 yields result_step 0..254.
- Reset mid-run aborts immediately. No done pulse is produced and no result is emitted.

Optional Feature:
SNN_SPIKE_COUNT_EN
- Defined: N_OUT saturating CNT_W counters, cleared on accepted start. In EMIT, each counter whose captured spike bit=1 increments and saturates at all-ones. The counters are exposed on spike_count and hold their values after done.
- Undefined: no counters and no spike_count port.

Decomposition:
- Package snn_sched_pkg: FSM state encoding (3-bit localparams IDLE=0, WAIT_FRAME=1, LOAD=2, RUN=3, EMIT=4); default widths N_IN/N_OUT; TIMEOUT default.
- One sub-module: snn_frame_fifo (synchronous FIFO, DEPTH/WIDTH parameters, push/pop/full/empty/head).

Test Plan:
- Push frames 0x01,0x02,0x03; start with num_steps=3. Bench answers snn_output_ready 5 cycles after each snn_input_ready with spikes=~input -> results 0xFE/0xFD/0xFC at steps 0,1,2, then done 1 cycle after the last result_valid, busy low.
- Push 5 frames with FIFO_DEPTH=4 and no run -> frame_ready drops after 4 accepted, 5th held; start num_steps=1 -> after the LOAD pop, 5th accepted.
- Start with num_steps=0 -> done pulse, busy never asserts, no snn_input_ready.
- Start with num_steps=2, bench never asserts snn_output_ready -> snn_enable high for exactly TIMEOUT_CYCLES, timeout_err=1, done pulse, no result_valid; next start clears timeout_err.
- Assert sys_clk_reset during RUN -> next cycle all outputs 0, FIFO empty, no done pulse.
- With SNN_SPIKE_COUNT_EN and CNT_W=2: 5 steps, every output 0x81 -> spike_count bits 7 and 0 saturate at 3, others 0.
